// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-requester mux arbiter: state encoding and
// hold-counter sizing helper.
package mux_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_A = 2'd1;
  localparam logic [1:0] ST_GNT_B = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    GNT_A = ST_GNT_A,
    GNT_B = ST_GNT_B
  } state_t;

  // Counter width able to hold MAX_HOLD-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_hold);
    if (max_hold > 32'd2) begin
      return $clog2(max_hold);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/mux_w.sv
// WIDTH-parameterised 2:1 data mux; s=0 selects a, s=1 selects b.
module mux_w #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mux_arb.sv
// Two-requester arbiter steering a shared mux. Define MUX_ARB_TIMEOUT_EN to
// limit a contested grant to MAX_HOLD consecutive cycles.
module mux_arb
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             grant_a,
  output logic             grant_b,
  output logic             s,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  state_t state_r;
  state_t state_nxt_s;
  logic   last_b_r;
  logic   last_b_nxt_s;
  logic   s_r;
  logic   s_nxt_s;
  logic   grant_a_r;
  logic   grant_b_r;
  logic   timeout_s;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int unsigned CW = cnt_width(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 32'd1);

  logic [CW-1:0] hold_cnt_r;

  // Hold counter: cycles spent in the current grant, saturating at HOLD_LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_r <= {CW{1'b0}};
    end else if ((state_nxt_s != state_r) || (state_r == IDLE)) begin
      hold_cnt_r <= {CW{1'b0}};
    end else if (hold_cnt_r != HOLD_LAST) begin
      hold_cnt_r <= hold_cnt_r + CW'(1);
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end

  assign timeout_s = (hold_cnt_r == HOLD_LAST);
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state arbitration; illegal encodings fall back to IDLE.
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE: begin
        if (req_a && req_b) begin
          state_nxt_s = last_b_r ? GNT_A : GNT_B;
        end else if (req_a) begin
          state_nxt_s = GNT_A;
        end else if (req_b) begin
          state_nxt_s = GNT_B;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT_A: begin
        if (req_a && !(req_b && timeout_s)) begin
          state_nxt_s = GNT_A;
        end else if (req_b) begin
          state_nxt_s = GNT_B;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT_B: begin
        if (req_b && !(req_a && timeout_s)) begin
          state_nxt_s = GNT_B;
        end else if (req_a) begin
          state_nxt_s = GNT_A;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Select and last-granted follow the grant being entered; IDLE keeps both.
  always_comb begin
    s_nxt_s      = s_r;
    last_b_nxt_s = last_b_r;
    case (state_nxt_s)
      GNT_A: begin
        s_nxt_s      = 1'b0;
        last_b_nxt_s = 1'b0;
      end
      GNT_B: begin
        s_nxt_s      = 1'b1;
        last_b_nxt_s = 1'b1;
      end
      default: begin
        s_nxt_s      = s_r;
        last_b_nxt_s = last_b_r;
      end
    endcase
  end

  // State and registered outputs; last-granted resets to B so A wins first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      grant_a_r <= 1'b0;
      grant_b_r <= 1'b0;
      s_r       <= 1'b0;
      last_b_r  <= 1'b1;
    end else begin
      state_r   <= state_nxt_s;
      grant_a_r <= (state_nxt_s == GNT_A);
      grant_b_r <= (state_nxt_s == GNT_B);
      s_r       <= s_nxt_s;
      last_b_r  <= last_b_nxt_s;
    end
  end

  assign grant_a = grant_a_r;
  assign grant_b = grant_b_r;
  assign s       = s_r;
  assign y_valid = grant_a_r | grant_b_r;

  mux_w #(
    .WIDTH (WIDTH)
  ) u_mux_w (
    .a (a),
    .b (b),
    .s (s_r),
    .y (y)
  );

endmodule

// File: tb/tb_mux_arb.sv
// Scoreboard bench for mux_arb: stimulus pushes expected outputs from an
// owner/hold-count model; a monitor pops and compares after each rising edge.
module tb_mux_arb;

  localparam int unsigned W  = 8;
  localparam int unsigned MH = 4;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  typedef struct {
    logic         ga;
    logic         gb;
    logic         s;
    logic [W-1:0] y;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_a = 1'b0;
  logic         req_b = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         grant_a, grant_b, s, y_valid;
  logic [W-1:0] y;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Model state: owner 0=none, 1=A, 2=B; held = cycles the owner has had the grant.
  int m_owner;
  int m_held;
  bit m_last_b;
  bit m_s;

  mux_arb #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
    .grant_a(grant_a), .grant_b(grant_b), .s(s), .y(y), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = 0;
    m_held   = 0;
    m_last_b = 1'b1;
    m_s      = 1'b0;
  endtask

  task automatic model_step(input bit ra, input bit rb);
    int nxt;
    bit mine, other;
    if (m_owner == 0) begin
      if (ra && rb)  nxt = m_last_b ? 1 : 2;
      else if (ra)   nxt = 1;
      else if (rb)   nxt = 2;
      else           nxt = 0;
    end else begin
      mine  = (m_owner == 1) ? ra : rb;
      other = (m_owner == 1) ? rb : ra;
      if (!mine)                                nxt = other ? 3 - m_owner : 0;
      else if (TMO && other && m_held >= int'(MH)) nxt = 3 - m_owner;
      else                                      nxt = m_owner;
    end
    if (nxt == 0)            m_held = 0;
    else if (nxt != m_owner) m_held = 1;
    else                     m_held = m_held + 1;
    if (nxt == 1) begin m_s = 1'b0; m_last_b = 1'b0; end
    if (nxt == 2) begin m_s = 1'b1; m_last_b = 1'b1; end
    m_owner = nxt;
  endtask

  task automatic step(input bit ra, input bit rb);
    exp_t e;
    @(negedge clk);
    req_a = ra;
    req_b = rb;
    a = W'($urandom);
    b = W'($urandom);
    model_step(ra, rb);
    e.ga = (m_owner == 1);
    e.gb = (m_owner == 2);
    e.s  = m_s;
    e.y  = m_s ? b : a;
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant_a", 32'(grant_a), 32'(e.ga));
        chk("grant_b", 32'(grant_b), 32'(e.gb));
        chk("s", 32'(s), 32'(e.s));
        chk("y_valid", 32'(y_valid), 32'(e.ga | e.gb));
        chk("y", 32'(y), 32'(e.y));
      end
    end
  end

  initial begin
    bit ra, rb;
    model_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_grant_a", 32'(grant_a), 32'd0);
    chk("rst_grant_b", 32'(grant_b), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_y_valid", 32'(y_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset, first tie to A, handover to B, B alone then release.
    repeat (5) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Both held continuously: alternation with timeout, A holds without it.
    repeat (20) step(1'b1, 1'b1);
    step(1'b0, 1'b0);

    // Sticky random requests so grants are held and contested for many cycles.
    ra = 1'b0;
    rb = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) ra = ~ra;
      if ($urandom_range(0, 3) == 0) rb = ~rb;
      step(ra, rb);
    end
    step(1'b0, 1'b0);

    // Asynchronous reset pulse in the middle of a B grant.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_grant_b", 32'(grant_b), 32'd0);
    chk("async_grant_a", 32'(grant_a), 32'd0);
    chk("async_s", 32'(s), 32'd0);
    chk("async_y_valid", 32'(y_valid), 32'd0);
    rst = 1'b0;
    model_reset();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
